// File: rtl/serial_bus_master.sv
// rtl/serial_bus_master.sv - initiator end of the bit-serial one-wire system bus
module serial_bus_master #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int ACK_TIMEOUT   = 16,
   parameter int DONE_TIMEOUT  = 255
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     rw,
   input  logic [2:0]               slave_id,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     bus_grant,
   output logic                     bus_request,
   output logic                     bus_util,
   output logic                     rd_wrt,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     done,
   output logic                     error,
   output logic                     busy,
   output logic [3:0]               state_out,
   inout  wire                      data_bus_serial
);

   localparam int CW  = 16;
   localparam int RXW = DATA_WIDTH - 1;
   localparam logic [CW-1:0] ACK_LIM   = CW'(ACK_TIMEOUT);
   localparam logic [CW-1:0] DONE_LIM  = CW'(DONE_TIMEOUT);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_REQ         = 4'd1,
      S_START       = 4'd2,
      S_SEND_SID    = 4'd3,
      S_SEND_ADDR   = 4'd4,
      S_WAIT_ACK    = 4'd5,
      S_ACK2        = 4'd6,
      S_WR_GUARD    = 4'd7,
      S_WR_START    = 4'd8,
      S_SEND_DATA   = 4'd9,
      S_WAIT_WR_ACK = 4'd10,
      S_WAIT_RD     = 4'd11,
      S_RX_DATA     = 4'd12,
      S_DONE        = 4'd13
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q;
   logic                     rw_q;
   logic [2:0]               sid_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [RXW-1:0]           rx_q;
   logic [DATA_WIDTH-1:0]    rdata_q;
   logic                     err_q, err_d;
   logic                     prev_zero_q;
   logic                     drv_en, drv_val;
   logic                     bus_bit;

   // Released bus reads as 1 through the external pull-up.
   assign bus_bit         = data_bus_serial;
   assign data_bus_serial = drv_en ? drv_val : 1'bz;

   // State register; reset drops the bus immediately since all outputs decode from state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state, error flag and serial driver decode.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      drv_en  = 1'b0;
      drv_val = 1'b1;
      case (state_q)
         S_IDLE:      if (start) state_d = S_REQ;
         S_REQ:       if (bus_grant) state_d = S_START;
         S_START: begin
            drv_en  = 1'b1;
            drv_val = 1'b0;
            if (cnt_q == CW'(1)) state_d = S_SEND_SID;
         end
         S_SEND_SID: begin
            drv_en  = 1'b1;
            drv_val = sid_q[2];
            if (cnt_q == CW'(2)) state_d = S_SEND_ADDR;
         end
         S_SEND_ADDR: begin
            drv_en  = 1'b1;
            drv_val = addr_q[ADDRESS_WIDTH-1];
            if (cnt_q == ADDR_LAST) state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!bus_bit) state_d = S_ACK2;
            else if (cnt_q == ACK_LIM) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_ACK2: begin
            if (bus_bit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = rw_q ? S_WR_GUARD : S_WAIT_RD;
            end
         end
         S_WR_GUARD: begin
            drv_en  = 1'b1;
            drv_val = 1'b1;
            state_d = S_WR_START;
         end
         S_WR_START: begin
            drv_en  = 1'b1;
            drv_val = 1'b0;
            state_d = S_SEND_DATA;
         end
         S_SEND_DATA: begin
            drv_en  = 1'b1;
            drv_val = wdata_q[DATA_WIDTH-1];
            if (cnt_q == DATA_LAST) state_d = S_WAIT_WR_ACK;
         end
         S_WAIT_WR_ACK: begin
            if (prev_zero_q && bus_bit) state_d = S_DONE;
            else if (cnt_q == DONE_LIM) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_WAIT_RD: begin
            if (!bus_bit) state_d = S_RX_DATA;
            else if (cnt_q == DONE_LIM) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_RX_DATA:   if (cnt_q == DATA_LAST) state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Request latch, shift registers, per-state counter and read-data capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         sid_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         prev_zero_q <= 1'b0;
      end else begin
         cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
         if (state_q == S_IDLE && start) begin
            rw_q    <= rw;
            sid_q   <= slave_id;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state_q == S_SEND_SID)  sid_q   <= {sid_q[1:0], 1'b0};
         if (state_q == S_SEND_ADDR) addr_q  <= {addr_q[ADDRESS_WIDTH-2:0], 1'b0};
         if (state_q == S_SEND_DATA) wdata_q <= {wdata_q[DATA_WIDTH-2:0], 1'b0};
         if (state_q == S_RX_DATA) begin
            rx_q <= RXW'({rx_q, bus_bit});
            if (cnt_q == DATA_LAST) rdata_q <= {rx_q, bus_bit};
         end
         prev_zero_q <= (state_q == S_WAIT_WR_ACK && state_d == S_WAIT_WR_ACK) ? ~bus_bit : 1'b0;
         if (state_d == S_DONE && state_q != S_DONE) err_q <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus_request = busy;
   assign bus_util    = busy && (state_q != S_REQ);
   assign rd_wrt      = bus_util & rw_q;
   assign done        = (state_q == S_DONE);
   assign error       = done & err_q;
   assign rdata       = rdata_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_serial_bus_master.sv
// tb/tb_serial_bus_master.sv - directed table-driven bench for serial_bus_master
module tb_serial_bus_master;

   localparam int ACK_NONE   = 0;
   localparam int ACK_GOOD   = 1;
   localparam int ACK_BROKEN = 2;

   typedef struct {
      logic        rw;
      logic [2:0]  sid;
      logic [14:0] addr;
      logic [7:0]  wdata;
      int          g;
      int          ack;
      logic        resp;
      logic [7:0]  rx;
      int          done_off;
      logic        exp_err;
      logic [7:0]  exp_rdata;
      logic        pulses;
   } txn_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, rw, bus_grant;
   logic [2:0]  slave_id;
   logic [14:0] addr;
   logic [7:0]  wdata;
   logic        bus_request, bus_util, rd_wrt, done, error, busy;
   logic [7:0]  rdata;
   logic [3:0]  state_out;
   logic        slv_en, slv_val;
   wire         data_bus_serial;

   int n_tests = 0;
   int n_fail  = 0;
   txn_t vec [8];

   pullup (data_bus_serial);
   assign data_bus_serial = slv_en ? slv_val : 1'bz;

   always #5 clk = ~clk;

   serial_bus_master dut (
      .clk(clk), .rstn(rstn), .start(start), .rw(rw), .slave_id(slave_id),
      .addr(addr), .wdata(wdata), .bus_grant(bus_grant), .bus_request(bus_request),
      .bus_util(bus_util), .rd_wrt(rd_wrt), .rdata(rdata), .done(done), .error(error),
      .busy(busy), .state_out(state_out), .data_bus_serial(data_bus_serial)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic run_txn(input txn_t v, input string tag);
      int r, done_t, req_cnt, pre_bad, z_bad, rdw_bad, lim;
      logic [19:0] abits;
      logic [9:0]  wbits;
      logic [7:0]  rxv;
      logic        req_first, err_at, util_at, busy_at, done_after, req_after;
      logic [7:0]  rdata_at;
      logic [3:0]  state_after;
      r = v.g + 22;
      lim = r + 300;
      done_t = -1;
      req_cnt = 0; pre_bad = 0; z_bad = 0; rdw_bad = 0;
      abits = '0; wbits = '0; rxv = v.rx;
      req_first = 1'b0; err_at = 1'bx; util_at = 1'bx; busy_at = 1'bx; rdata_at = 'x;
      done_after = 1'bx; req_after = 1'bx; state_after = 'x;
      @(negedge clk);
      start = 1'b1; rw = v.rw; slave_id = v.sid; addr = v.addr; wdata = v.wdata;
      bus_grant = 1'b0;
      @(negedge clk);
      start = 1'b0;
      rw = ~v.rw; slave_id = ~v.sid; addr = ~v.addr; wdata = ~v.wdata;
      for (int t = 1; t <= lim; t++) begin
         if (t > 1) @(negedge clk);
         bus_grant = (t >= v.g + 1) && (done_t < 0);
         start = v.pulses && (t == 5 || t == r + 1);
         slv_en = 1'b0; slv_val = 1'b1;
         if (v.ack != ACK_NONE && (t == r + 2 || t == r + 3)) begin
            slv_en = 1'b1;
            slv_val = (t == r + 3) && (v.ack == ACK_BROKEN);
         end
         if (v.ack == ACK_GOOD && v.resp) begin
            if (v.rw) begin
               if (t == r + 16) begin slv_en = 1'b1; slv_val = 1'b0; end
               if (t == r + 17) begin slv_en = 1'b1; slv_val = 1'b1; end
            end else begin
               if (t == r + 6) begin slv_en = 1'b1; slv_val = 1'b0; end
               if (t >= r + 7 && t <= r + 14) begin
                  slv_en = 1'b1; slv_val = rxv[3'(r + 14 - t)];
               end
            end
         end
         #1;
         if (t == 1) req_first = bus_request;
         if (t <= v.g + 1) begin
            req_cnt += int'(bus_request);
            if (data_bus_serial !== 1'b1) pre_bad++;
         end
         if (t >= v.g + 2 && t <= v.g + 21) abits = {abits[18:0], data_bus_serial};
         if (v.rw && t >= r + 4 && t <= r + 13) wbits = {wbits[8:0], data_bus_serial};
         if (t >= r && done_t < 0 && !slv_en && !(v.rw && v.ack == ACK_GOOD && t >= r + 4 && t <= r + 13)
             && data_bus_serial !== 1'b1) z_bad++;
         if (t >= v.g + 2 && done_t < 0 && done !== 1'b1 && (bus_util !== 1'b1 || rd_wrt !== v.rw)) rdw_bad++;
         if (done === 1'b1 && done_t < 0) begin
            done_t = t; err_at = error; util_at = bus_util; busy_at = busy; rdata_at = rdata;
         end else if (done_t >= 0 && t == done_t + 1) begin
            done_after = done; req_after = bus_request; state_after = state_out;
            break;
         end
      end
      start = 1'b0; slv_en = 1'b0; bus_grant = 1'b0;
      check({tag, "_req_latency"}, 32'(req_first), 32'd1);
      check({tag, "_req_cycles"}, req_cnt, v.g + 1);
      check({tag, "_bus_idle_before_grant"}, pre_bad, 0);
      check({tag, "_addr_bits"}, 32'(abits), 32'({2'b00, v.sid, v.addr}));
      if (v.rw && v.ack == ACK_GOOD) check({tag, "_wr_bits"}, 32'(wbits), 32'({2'b10, v.wdata}));
      check({tag, "_no_stray_drive"}, z_bad, 0);
      check({tag, "_util_rdwrt"}, rdw_bad, 0);
      check({tag, "_done_time"}, done_t, r + v.done_off);
      check({tag, "_error"}, 32'(err_at), 32'(v.exp_err));
      check({tag, "_rdata"}, 32'(rdata_at), 32'(v.exp_rdata));
      check({tag, "_util_at_done"}, 32'(util_at), 32'd0);
      check({tag, "_busy_at_done"}, 32'(busy_at), 32'd0);
      check({tag, "_done_one_cycle"}, 32'(done_after), 32'd0);
      check({tag, "_idle_after"}, {27'd0, req_after, state_after}, 32'd0);
   endtask

   initial begin
      // rw sid addr wdata g ack resp rx done_off err rdata pulses
      vec[0] = '{1'b1, 3'b101, 15'h1234, 8'hA5, 0,  ACK_GOOD,   1'b1, 8'h00, 18,  1'b0, 8'h00, 1'b0};
      vec[1] = '{1'b0, 3'b010, 15'h7FFF, 8'h00, 0,  ACK_GOOD,   1'b1, 8'h3C, 15,  1'b0, 8'h3C, 1'b0};
      vec[2] = '{1'b0, 3'b001, 15'h0000, 8'h00, 0,  ACK_NONE,   1'b0, 8'h00, 17,  1'b1, 8'h3C, 1'b0};
      vec[3] = '{1'b1, 3'b111, 15'h5555, 8'h0F, 10, ACK_GOOD,   1'b1, 8'h00, 18,  1'b0, 8'h3C, 1'b1};
      vec[4] = '{1'b0, 3'b000, 15'h0001, 8'h00, 0,  ACK_BROKEN, 1'b0, 8'h00, 4,   1'b1, 8'h3C, 1'b0};
      vec[5] = '{1'b0, 3'b011, 15'h4000, 8'h00, 0,  ACK_GOOD,   1'b0, 8'h00, 260, 1'b1, 8'h3C, 1'b0};
      vec[6] = '{1'b0, 3'b110, 15'h2AAA, 8'h00, 2,  ACK_GOOD,   1'b1, 8'h81, 15,  1'b0, 8'h81, 1'b0};
      vec[7] = '{1'b1, 3'b100, 15'h0F0F, 8'hFF, 0,  ACK_GOOD,   1'b0, 8'h00, 270, 1'b1, 8'h81, 1'b0};

      rstn = 1'b0; start = 1'b0; rw = 1'b0; slave_id = '0; addr = '0; wdata = '0;
      bus_grant = 1'b0; slv_en = 1'b0; slv_val = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", {23'd0, bus_request, bus_util, rd_wrt, done, error, busy, state_out == 4'd0},
            32'd1);
      check("reset_rdata", 32'(rdata), 32'd0);
      check("reset_bus_released", 32'(data_bus_serial), 32'd1);
      rstn = 1'b1;
      @(negedge clk);
      #1 check("post_reset_idle", 32'(state_out), 32'd0);

      for (int i = 0; i < 8; i++) run_txn(vec[i], $sformatf("v%0d", i));

      // Asynchronous reset in the middle of the address phase.
      @(negedge clk);
      start = 1'b1; rw = 1'b1; slave_id = 3'b011; addr = 15'h0000; wdata = 8'h55; bus_grant = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #1 check("rst_mid_state", 32'(state_out), 32'd4);
      check("rst_mid_bus_driven_low", 32'(data_bus_serial), 32'd0);
      #2 rstn = 1'b0;
      #1;
      check("rst_async_outputs", {25'd0, bus_request, bus_util, rd_wrt, done, error, busy, |state_out},
            32'd0);
      check("rst_async_bus_released", 32'(data_bus_serial), 32'd1);
      check("rst_async_rdata", 32'(rdata), 32'd0);
      bus_grant = 1'b0;
      begin
         int done_seen;
         done_seen = 0;
         repeat (3) begin
            @(negedge clk);
            #1 done_seen += int'(done);
         end
         rstn = 1'b1;
         repeat (2) begin
            @(negedge clk);
            #1 done_seen += int'(done);
         end
         check("rst_no_done", done_seen, 0);
      end
      check("rst_release_idle", 32'(state_out), 32'd0);
      run_txn(vec[0], "post_rst_write");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
